cgra_tile_ctx_mem: RTL and testbench

Per-tile configuration context memory and sequencer, directly downstream of the CGRA CSR block. It accepts per-context configuration writes over the tile write port (addr/data/wr_en/valid/ready). On a run command, it replays contexts 0..N-1 cyclically, one per non-stalled cycle, for a programmed number of iterations. It presents the current context's configuration word to the tile datapath and signals completion.

---
 rtl/cgra_cfg_pkg.sv | 21 ++
 rtl/cgra_tile_ctx_mem.sv | 138 +++++++++++++
 tb/tb_cgra_tile_ctx_mem.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared CGRA tile configuration types: the per-context configuration word
// and the context sequencer state encoding.
package cgra_cfg_pkg;

  localparam int unsigned CGRA_CFG_W = 49;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic        predicate;
    logic [11:0] fu_in;
    logic [23:0] outport;
    logic [5:0]  predicate_in;
  } cgra_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctx_state_e;

endpackage

// File: rtl/cgra_tile_ctx_mem.sv
// Per-tile context memory: accepts configuration writes while idle and
// replays contexts 0..count-1 cyclically for a programmed number of iterations.
module cgra_tile_ctx_mem
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned KernelSize = 4,
  parameter int unsigned IterWidth  = 16,
  parameter int unsigned IdxWidth   = $clog2(KernelSize)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IdxWidth-1:0]   cfg_addr_i,
  input  cgra_cfg_t             cfg_data_i,
  input  logic                  cfg_wr_en_i,
  input  logic                  cfg_wr_valid_i,
  output logic                  cfg_ready_o,
  input  logic                  run_i,
  input  logic [IdxWidth:0]     ctx_count_i,
  input  logic [IterWidth-1:0]  iter_count_i,
  input  logic                  stall_i,
  input  logic                  abort_i,
  output cgra_cfg_t             ctx_o,
  output logic [IdxWidth-1:0]   ctx_idx_o,
  output logic                  ctx_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [KernelSize-1:0] written_mask_o
);

  localparam logic [IdxWidth:0] CntMax = (IdxWidth + 1)'(KernelSize);

  ctx_state_e            r_state;
  ctx_state_e            w_state_nxt;
  cgra_cfg_t             r_mem [KernelSize];
  logic [KernelSize-1:0] r_written;
  logic [IdxWidth-1:0]   r_ctx_idx;
  logic [IdxWidth-1:0]   r_ctx_last;
  logic [IterWidth-1:0]  r_iter;
  logic [IterWidth-1:0]  r_iter_last;
  logic                  r_err;

  logic w_wr_fire;
  logic w_run_req;
  logic w_run_bad;
  logic w_run_ok;
  logic w_advance;
  logic w_wrap;
  logic w_last_iter;

  assign w_wr_fire   = cfg_wr_valid_i & cfg_ready_o & cfg_wr_en_i;
  assign w_run_req   = (r_state == ST_IDLE) & run_i;
  assign w_run_bad   = w_run_req & ((ctx_count_i == '0) | (ctx_count_i > CntMax));
  assign w_run_ok    = w_run_req & ~w_run_bad;
  assign w_advance   = (r_state == ST_RUN) & ~abort_i & ~stall_i;
  assign w_wrap      = (r_ctx_idx == r_ctx_last);
  // Equality against the latched count-1 lets the maximum count run without overflow.
  assign w_last_iter = (r_iter == r_iter_last);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < KernelSize; i++) begin
        r_mem[i] <= '0;
      end
      r_written <= '0;
    end else if (w_wr_fire) begin
      r_mem[cfg_addr_i]     <= cfg_data_i;
      r_written[cfg_addr_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_ctx_idx   <= '0;
      r_ctx_last  <= '0;
      r_iter      <= '0;
      r_iter_last <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_run_bad;
      if (w_run_ok) begin
        r_ctx_last  <= IdxWidth'(ctx_count_i - 1'b1);
        r_iter_last <= iter_count_i - 1'b1;
        r_ctx_idx   <= '0;
        r_iter      <= '0;
      end else if ((r_state == ST_RUN) && abort_i) begin
        r_ctx_idx <= '0;
      end else if (w_advance) begin
        if (w_wrap) begin
          r_ctx_idx <= '0;
          r_iter    <= r_iter + 1'b1;
        end else begin
          r_ctx_idx <= r_ctx_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready_o = 1'b0;
    ctx_valid_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (w_run_ok) begin
          w_state_nxt = (iter_count_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        ctx_valid_o = 1'b1;
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_advance && w_wrap && w_last_iter) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ctx_o          = r_mem[r_ctx_idx];
  assign ctx_idx_o      = r_ctx_idx;
  assign err_o          = r_err;
  assign written_mask_o = r_written;

endmodule

// File: tb/tb_cgra_tile_ctx_mem.sv
// Self-checking bench for cgra_tile_ctx_mem against a transaction-level model
// (memory image plus an expected context-index queue per run).
module tb_cgra_tile_ctx_mem;
  import cgra_cfg_pkg::*;

  localparam int K  = 4;
  localparam int IW = 16;
  localparam int XW = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [XW-1:0] cfg_addr_i;
  cgra_cfg_t     cfg_data_i;
  logic          cfg_wr_en_i;
  logic          cfg_wr_valid_i;
  logic          cfg_ready_o;
  logic          run_i;
  logic [XW:0]   ctx_count_i;
  logic [IW-1:0] iter_count_i;
  logic          stall_i;
  logic          abort_i;
  cgra_cfg_t     ctx_o;
  logic [XW-1:0] ctx_idx_o;
  logic          ctx_valid_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [K-1:0]  written_mask_o;

  cgra_tile_ctx_mem #(.KernelSize(K), .IterWidth(IW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_wr_en_i(cfg_wr_en_i), .cfg_wr_valid_i(cfg_wr_valid_i),
    .cfg_ready_o(cfg_ready_o), .run_i(run_i),
    .ctx_count_i(ctx_count_i), .iter_count_i(iter_count_i),
    .stall_i(stall_i), .abort_i(abort_i),
    .ctx_o(ctx_o), .ctx_idx_o(ctx_idx_o), .ctx_valid_o(ctx_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .written_mask_o(written_mask_o)
  );

  always #5 clk = ~clk;

  cgra_cfg_t    mem_m [K];
  logic [K-1:0] mask_m;
  int           n_chk;
  int           n_pass;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic cgra_cfg_t rnd_cfg();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return cgra_cfg_t'(r[CGRA_CFG_W-1:0]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < K; i++) mem_m[i] = '0;
    mask_m = '0;
  endtask

  // Called at a negedge while idle; returns at the following negedge.
  task automatic write_cfg(input int a, input cgra_cfg_t d, input bit en);
    cfg_addr_i     = XW'(a);
    cfg_data_i     = d;
    cfg_wr_en_i    = en;
    cfg_wr_valid_i = 1'b1;
    check_val("wr_ready", 64'(cfg_ready_o), 64'd1);
    @(negedge clk);
    if (en) begin
      mem_m[a]  = d;
      mask_m[a] = 1'b1;
    end
    cfg_wr_valid_i = 1'b0;
    cfg_wr_en_i    = 1'b0;
    check_val("wr_mask", 64'(written_mask_o), 64'(mask_m));
  endtask

  // stall_mode: 0 none, 1 random, 2 two cycles at first idx 1.
  // cowr: 0 none, 1 write in the run cycle, 2 write held during the run.
  task automatic do_run(input int cnt, input int iter, input int stall_mode,
                        input int abort_at, input int cowr);
    int        q[$];
    int        valid_n;
    int        cyc;
    int        s1_left;
    bit        s1_done;
    bit        st;
    bit        legal;
    cgra_cfg_t wd;
    int        wa;
    valid_n = 0;
    cyc     = 0;
    s1_left = 0;
    s1_done = 1'b0;
    legal   = (cnt >= 1) && (cnt <= K);
    wd      = rnd_cfg();
    wa      = $urandom_range(0, K - 1);
    ctx_count_i  = (XW + 1)'(cnt);
    iter_count_i = IW'(iter);
    run_i        = 1'b1;
    if (cowr == 1) begin
      cfg_addr_i = XW'(wa); cfg_data_i = wd; cfg_wr_en_i = 1'b1; cfg_wr_valid_i = 1'b1;
    end
    @(negedge clk);
    run_i = 1'b0;
    if (cowr == 1) begin
      mem_m[wa] = wd; mask_m[wa] = 1'b1;
      cfg_wr_valid_i = 1'b0; cfg_wr_en_i = 1'b0;
    end else if (cowr == 2) begin
      cfg_addr_i = XW'(wa); cfg_data_i = wd; cfg_wr_en_i = 1'b1; cfg_wr_valid_i = 1'b1;
    end
    if (!legal) begin
      check_val("err_pulse", 64'(err_o), 64'd1);
      check_val("err_busy", 64'(busy_o), 64'd0);
      check_val("err_valid", 64'(ctx_valid_o), 64'd0);
      @(negedge clk);
      check_val("err_clear", 64'(err_o), 64'd0);
      check_val("err_busy2", 64'(busy_o), 64'd0);
      return;
    end
    if (iter == 0) begin
      check_val("zit_done", 64'(done_o), 64'd1);
      check_val("zit_valid", 64'(ctx_valid_o), 64'd0);
      @(negedge clk);
      check_val("zit_done2", 64'(done_o), 64'd0);
      check_val("zit_busy", 64'(busy_o), 64'd0);
      check_val("zit_valid2", 64'(ctx_valid_o), 64'd0);
      return;
    end
    for (int it = 0; it < iter; it++)
      for (int c = 0; c < cnt; c++) q.push_back(c);
    while (q.size() > 0 && cyc < 2000) begin
      cyc++;
      valid_n++;
      check_val("run_valid", 64'(ctx_valid_o), 64'd1);
      check_val("run_idx", 64'(ctx_idx_o), 64'(q[0]));
      check_val("run_ctx", 64'(ctx_o), 64'(mem_m[q[0]]));
      check_val("run_done", 64'(done_o), 64'd0);
      check_val("run_busy", 64'(busy_o), 64'd1);
      if (cowr == 2) check_val("holdoff_ready", 64'(cfg_ready_o), 64'd0);
      st = 1'b0;
      if (stall_mode == 1) st = ($urandom_range(0, 3) == 0);
      if (stall_mode == 2) begin
        if (q[0] == 1 && !s1_done) begin s1_left = 2; s1_done = 1'b1; end
        if (s1_left > 0) begin st = 1'b1; s1_left--; end
      end
      if (abort_at == valid_n) begin
        abort_i = 1'b1;
        stall_i = st;
        @(negedge clk);
        abort_i = 1'b0;
        stall_i = 1'b0;
        check_val("abort_valid", 64'(ctx_valid_o), 64'd0);
        check_val("abort_busy", 64'(busy_o), 64'd0);
        check_val("abort_done", 64'(done_o), 64'd0);
        @(negedge clk);
        check_val("abort_done2", 64'(done_o), 64'd0);
        return;
      end
      stall_i = st;
      @(negedge clk);
      if (!st) void'(q.pop_front());
    end
    stall_i = 1'b0;
    if (q.size() > 0) check_val("run_timeout", 64'(q.size()), 64'd0);
    check_val("fin_done", 64'(done_o), 64'd1);
    check_val("fin_valid", 64'(ctx_valid_o), 64'd0);
    check_val("fin_busy", 64'(busy_o), 64'd1);
    check_val("fin_idx", 64'(ctx_idx_o), 64'd0);
    if (cowr == 2) check_val("holdoff_ready_done", 64'(cfg_ready_o), 64'd0);
    @(negedge clk);
    check_val("post_done", 64'(done_o), 64'd0);
    check_val("post_busy", 64'(busy_o), 64'd0);
    if (cowr == 2) begin
      check_val("holdoff_ready_idle", 64'(cfg_ready_o), 64'd1);
      @(negedge clk);
      mem_m[wa] = wd; mask_m[wa] = 1'b1;
      cfg_wr_valid_i = 1'b0; cfg_wr_en_i = 1'b0;
      check_val("holdoff_mask", 64'(written_mask_o), 64'(mask_m));
    end
  endtask

  initial begin
    int op, cnt, iter, sm, ab, cw;
    n_chk = 0;
    n_pass = 0;
    clear_model();
    rst_i = 1'b1;
    cfg_addr_i = '0; cfg_data_i = '0; cfg_wr_en_i = 1'b0; cfg_wr_valid_i = 1'b0;
    run_i = 1'b0; ctx_count_i = '0; iter_count_i = '0; stall_i = 1'b0; abort_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    check_val("rst_mask", 64'(written_mask_o), 64'd0);
    check_val("rst_idx", 64'(ctx_idx_o), 64'd0);
    check_val("rst_ctx", 64'(ctx_o), 64'd0);
    check_val("rst_valid", 64'(ctx_valid_o), 64'd0);
    check_val("rst_busy", 64'(busy_o), 64'd0);
    check_val("rst_done", 64'(done_o), 64'd0);
    check_val("rst_err", 64'(err_o), 64'd0);
    check_val("rst_ready", 64'(cfg_ready_o), 64'd1);

    for (int i = 0; i < K; i++) write_cfg(i, cgra_cfg_t'(49'(i + 1)), 1'b1);
    write_cfg(1, cgra_cfg_t'(49'h1_dead_beef), 1'b0);
    check_val("mask_full", 64'(written_mask_o), 64'hf);
    do_run(4, 1, 0, 0, 0);
    do_run(3, 2, 0, 0, 0);
    do_run(4, 1, 2, 0, 0);
    do_run(0, 1, 0, 0, 0);
    do_run(5, 1, 0, 0, 0);
    do_run(2, 0, 0, 0, 0);
    do_run(3, 2, 0, 0, 2);
    do_run(4, 1, 0, 0, 1);
    do_run(4, 3, 0, 2, 0);
    do_run(4, 3, 1, 3, 0);

    ctx_count_i = 3'd4; iter_count_i = 16'd100; run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check_val("arst_valid", 64'(ctx_valid_o), 64'd0);
    check_val("arst_busy", 64'(busy_o), 64'd0);
    check_val("arst_idx", 64'(ctx_idx_o), 64'd0);
    check_val("arst_ctx", 64'(ctx_o), 64'd0);
    check_val("arst_mask", 64'(written_mask_o), 64'd0);
    check_val("arst_ready", 64'(cfg_ready_o), 64'd1);
    clear_model();
    @(negedge clk);
    rst_i = 1'b0;
    do_run(4, 1, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        write_cfg($urandom_range(0, K - 1), rnd_cfg(), ($urandom_range(0, 3) != 0));
      end else begin
        cnt  = $urandom_range(0, 5);
        iter = $urandom_range(0, 3);
        sm   = $urandom_range(0, 1);
        ab   = 0;
        if (cnt >= 1 && cnt <= K && iter > 0 && $urandom_range(0, 3) == 0)
          ab = $urandom_range(1, cnt * iter);
        cw = $urandom_range(0, 2);
        if (cw == 2 && !(cnt >= 1 && cnt <= K && iter > 0 && ab == 0)) cw = 1;
        do_run(cnt, iter, sm, ab, cw);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
